// File: rtl/shotclock_display_alarm.sv
// Shot-clock display and expiry alarm: 5-bit count -> two active-low 7-seg digits, timed buzzer, blinking "00".
// Optional low-time warning blink is enabled by defining LOW_TIME_WARN_EN.
module shotclock_display_alarm #(
   parameter int BUZZ_CYCLES  = 100000000,
   parameter int BLINK_CYCLES = 12500000,
   parameter int WARN_THRESH  = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] count,
   input  logic       pause,
   output logic [7:0] hex1,
   output logic [7:0] hex0,
   output logic       buzzer,
   output logic       expired
);

   localparam int BW = $clog2(BUZZ_CYCLES);
   localparam int KW = $clog2(BLINK_CYCLES);
   localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_CYCLES - 1);
   localparam logic [KW-1:0] BLINK_LAST = KW'(BLINK_CYCLES - 1);
   localparam logic [4:0]    WARN_V     = 5'(WARN_THRESH);
`ifdef LOW_TIME_WARN_EN
   localparam bit WARN_EN = 1'b1;
`else
   localparam bit WARN_EN = 1'b0;
`endif

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {IDLE, BUZZ, HOLD} state_t;

   state_t          state, state_n;
   logic [4:0]      count_q;
   logic [BW-1:0]   bt, bt_n;
   logic [KW-1:0]   kt, kt_n;
   logic            ph, ph_n;
   logic            win_q, win_n;
   logic            expire_ev;
   logic [4:0]      tens, ones;
   logic [7:0]      hex1_n, hex0_n;
   logic            buzzer_n, expired_n;

   function automatic logic [7:0] seg(input logic [4:0] d);
      case (d)
         5'd0:    seg = 8'hC0;
         5'd1:    seg = 8'hF9;
         5'd2:    seg = 8'hA4;
         5'd3:    seg = 8'hB0;
         5'd4:    seg = 8'h99;
         5'd5:    seg = 8'h92;
         5'd6:    seg = 8'h82;
         5'd7:    seg = 8'hF8;
         5'd8:    seg = 8'h80;
         5'd9:    seg = 8'h90;
         default: seg = 8'hFF;
      endcase
   endfunction

   // A zero that was already present (e.g. out of reset) is not an expiry.
   assign expire_ev = (count == 5'd0) && (count_q != 5'd0);
   assign tens      = count / 5'd10;
   assign ones      = count % 5'd10;

   always_comb begin
      state_n = state;
      bt_n    = bt;
      case (state)
         IDLE: begin
            if (expire_ev) begin
               state_n = BUZZ;
               bt_n    = '0;
            end
         end
         BUZZ: begin
            if (expire_ev) begin
               bt_n = '0;
            end else if (!pause) begin
               if (bt == BUZZ_LAST) begin
                  state_n = (count == 5'd0) ? HOLD : IDLE;
                  bt_n    = '0;
               end else begin
                  bt_n = bt + 1'b1;
               end
            end
         end
         HOLD: begin
            if (count != 5'd0) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // One blink phase counter serves both HOLD and the low-time window.
   always_comb begin
      win_n = WARN_EN && (state_n == IDLE) && !pause &&
              (count >= 5'd1) && (count <= WARN_V);
      kt_n  = kt;
      ph_n  = ph;
      if (((state_n == HOLD) && (state != HOLD)) || (win_n && !win_q)) begin
         kt_n = '0;
         ph_n = 1'b1;
      end else if ((state_n == HOLD) || win_n) begin
         if (kt == BLINK_LAST) begin
            kt_n = '0;
            ph_n = !ph;
         end else begin
            kt_n = kt + 1'b1;
         end
      end
   end

   always_comb begin
      hex1_n    = SEG_BLANK;
      hex0_n    = SEG_BLANK;
      buzzer_n  = (state_n == BUZZ) && !pause;
      expired_n = (state_n != IDLE);
      case (state_n)
         IDLE: begin
            hex1_n = (count < 5'd10) ? SEG_BLANK : seg(tens);
            hex0_n = seg(ones);
            if (pause) hex0_n[7] = 1'b0;
            if (win_n && !ph_n) begin
               hex1_n = SEG_BLANK;
               hex0_n = SEG_BLANK;
            end
         end
         BUZZ: begin
            hex1_n = SEG_0;
            hex0_n = SEG_0;
         end
         HOLD: begin
            hex1_n = ph_n ? SEG_0 : SEG_BLANK;
            hex0_n = ph_n ? SEG_0 : SEG_BLANK;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count_q <= 5'd0;
         bt      <= '0;
         kt      <= '0;
         ph      <= 1'b1;
         win_q   <= 1'b0;
         hex1    <= SEG_BLANK;
         hex0    <= SEG_BLANK;
         buzzer  <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= state_n;
         count_q <= count;
         bt      <= bt_n;
         kt      <= kt_n;
         ph      <= ph_n;
         win_q   <= win_n;
         hex1    <= hex1_n;
         hex0    <= hex0_n;
         buzzer  <= buzzer_n;
         expired <= expired_n;
      end
   end

endmodule

// File: doc/shotclock_display_alarm.md
Name: shotclock_display_alarm

Overview:
Downstream consumer of the shot-clock countdown value. Converts the 5-bit count (0–31) into two active-low DE10-Lite seven-segment digit patterns with leading-zero blanking. Detects expiry (count falling to 0) and drives a timed buzzer, then blinks "00" until the clock is restarted. Sits between the countdown counter and the board HEX/buzzer GPIO pins.

Parameters:
BUZZ_CYCLES, 100000000, buzzer on-time in clk cycles (2 s at 50 MHz)
BLINK_CYCLES, 12500000, half-period of all display blinking in clk cycles
WARN_THRESH, 5, upper bound of low-time warning window (used only with optional feature)

Ports:
clk  input  1  50 MHz system clock; the block's only clock
rst_n  input  1  asynchronous, active-low reset
count  input  5  countdown value from shot-clock counter, 0–31
pause  input  1  pause level from the same source that pauses the counter
hex1  output  8  tens digit, active-low, bit order {dp,g,f,e,d,c,b,a}
hex0  output  8  ones digit, same encoding
buzzer  output  1  buzzer drive, active-high
expired  output  1  high while in BUZZ or HOLD

Behaviour:
- Reset (rst_n=0, async): hex1=hex0=8'hFF (blank), buzzer=0, expired=0, state=IDLE, count_q=0, all timers=0.
- count_q registers count every cycle. Expiry event = (count==0) && (count_q!=0). No event if count is already 0 coming out of reset.
- Digit codes: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 blank=FF.
- Tens = count/10 (0–3), ones = count%10; tens blanked when count<10 (IDLE only).
- All outputs registered; hex outputs reflect count 1 cycle after count changes.
- FSM states: IDLE, BUZZ, HOLD.
- IDLE: shows count. hex0 dp (bit7) = 0 while pause=1, else 1. Expiry event -> BUZZ, buzz timer cleared.
- BUZZ: display "00" (C0/C0) steady. buzzer=1 while pause=0; timer increments only while pause=0; buzzer=0 and timer frozen while pause=1. New expiry event in BUZZ restarts the timer at 0. At timer==BUZZ_CYCLES-1 (unpaused): -> HOLD if count==0, else -> IDLE. Buzzer on-time is therefore exactly BUZZ_CYCLES unpaused cycles.
- HOLD: blink phase counter cleared on entry, phase starts ON. ON: C0/C0; OFF: FF/FF; phase toggles every BLINK_CYCLES cycles; pause ignored. count!=0 -> IDLE next cycle (display shows the new count).
- expired=1 in BUZZ and HOLD, 0 in IDLE; registered with state.
- Timers sized by $clog2 of their parameters; no wrap beyond terminal count.
- rst_n assertion mid-BUZZ/HOLD: immediate return to reset values; no buzz resumes after release.

Optional Feature:
Macro LOW_TIME_WARN_EN. Defined: in IDLE with pause=0 and 1<=count<=WARN_THRESH, both digits blink with the same BLINK_CYCLES phase counter (OFF phase = FF/FF); the counter clears when entering the window. Not defined: IDLE display is always steady; WARN_THRESH unused.

Test Plan:
(bench params BUZZ_CYCLES=20, BLINK_CYCLES=4, WARN_THRESH=5)
1. rst_n=0 -> hex1=hex0=FF, buzzer=0, expired=0; release, count=24 -> next cycle hex1=A4, hex0=99.
2. count=7 -> hex1=FF, hex0=F8; count=30 -> hex1=B0, hex0=C0; pause=1 at count=30 -> hex0=40.
3. count 1->0 -> next cycle buzzer=1, expired=1 for exactly 20 cycles; then HOLD: C0/C0 4 cycles, FF/FF 4 cycles, repeat; count=24 -> expired=0, hex1=A4, hex0=99.
4. pause=1 for 10 cycles starting 5 cycles into BUZZ -> buzzer=0 during pause, total buzzer-high cycles still 20.
5. rst_n=0 mid-BUZZ with count held at 0 -> buzzer=0 immediately; after release no re-trigger, expired stays 0.
6. LOW_TIME_WARN_EN defined, count=3, pause=0 -> digits alternate F9-class pattern B0/FF every 4 cycles; undefined -> steady hex1=FF, hex0=B0.
